// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch prediction opcodes, funct3 codes and queue entry type
package bp_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int BP_ADDR_W = 32;

    typedef struct packed {
        logic [BP_ADDR_W-1:0] pc;
        logic                 pred_taken;
        logic [BP_ADDR_W-1:0] pred_target;
    } bq_entry_t;

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational branch condition evaluation from funct3 and operands
module branch_compare
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic                  taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order branch queue, execute-time resolution, redirect and BHT update
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int ADDRESS_BITS     = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int QUEUE_DEPTH      = 8,
    parameter int LOG2_QUEUE_DEPTH = $clog2(QUEUE_DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enq_valid,
    input  logic [ADDRESS_BITS-1:0]     enq_pc,
    input  logic                        enq_pred_taken,
    input  logic [ADDRESS_BITS-1:0]     enq_pred_target,
    output logic                        enq_ready,
    input  logic                        res_valid,
    input  logic [2:0]                  res_funct3,
    input  logic [DATA_WIDTH-1:0]       res_rs1,
    input  logic [DATA_WIDTH-1:0]       res_rs2,
    input  logic [12:0]                 res_imm,
    output logic                        mispred,
    output logic [ADDRESS_BITS-1:0]     redirect_pc,
    output logic                        actual_pred,
    output logic [6:0]                  update_opcode,
    output logic [ADDRESS_BITS-1:0]     update_pc,
    output logic [LOG2_QUEUE_DEPTH:0]   occupancy,
    output logic [31:0]                 mispred_count,
    output logic                        underflow_err
);

    localparam int PW = LOG2_QUEUE_DEPTH;

    bq_entry_t                   queue_q [QUEUE_DEPTH];
    bq_entry_t                   enq_entry;
    bq_entry_t                   head;

    logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [PW:0]                 occ_q, occ_d;
    logic                        mispred_q, mispred_d;
    logic [ADDRESS_BITS-1:0]     redirect_pc_q, redirect_pc_d;
    logic                        actual_pred_q, actual_pred_d;
    logic [6:0]                  update_opcode_q, update_opcode_d;
    logic [ADDRESS_BITS-1:0]     update_pc_q, update_pc_d;
    logic [31:0]                 mispred_count_q, mispred_count_d;
    logic                        underflow_q, underflow_d;

    logic                        taken;
    logic                        res_fire, enq_fire, is_mispred;
    logic [ADDRESS_BITS-1:0]     head_pc, head_tgt, imm_ext, taken_tgt, next_pc;

    branch_compare #(.DATA_WIDTH(DATA_WIDTH)) u_compare (
        .funct3 (res_funct3),
        .rs1    (res_rs1),
        .rs2    (res_rs2),
        .taken  (taken)
    );

    always_comb begin
        enq_ready             = (occ_q != (PW+1)'(QUEUE_DEPTH));
        enq_entry.pc          = BP_ADDR_W'(enq_pc);
        enq_entry.pred_taken  = enq_pred_taken;
        enq_entry.pred_target = BP_ADDR_W'(enq_pred_target);

        head      = queue_q[head_q];
        head_pc   = ADDRESS_BITS'(head.pc);
        head_tgt  = ADDRESS_BITS'(head.pred_target);
        imm_ext   = {{(ADDRESS_BITS-13){res_imm[12]}}, res_imm};
        taken_tgt = head_pc + imm_ext;
        next_pc   = taken ? taken_tgt : head_pc + ADDRESS_BITS'(4);

        res_fire   = res_valid && (occ_q != '0);
        is_mispred = res_fire && ((taken != head.pred_taken) ||
                                  (taken && (taken_tgt != head_tgt)));
        // The enqueue alongside a mispredict is wrong-path and is dropped.
        enq_fire   = enq_valid && enq_ready && !is_mispred;

        if (is_mispred) begin
            head_d = head_q + PW'(1);
            tail_d = head_q + PW'(1);
            occ_d  = '0;
        end else begin
            head_d = head_q + PW'(res_fire);
            tail_d = tail_q + PW'(enq_fire);
            occ_d  = occ_q + (PW+1)'(enq_fire) - (PW+1)'(res_fire);
        end

        mispred_d       = is_mispred;
        update_opcode_d = res_fire ? OPC_BRANCH : 7'b0;
        redirect_pc_d   = res_fire ? next_pc : redirect_pc_q;
        update_pc_d     = res_fire ? head_pc : update_pc_q;
        actual_pred_d   = res_fire ? taken : actual_pred_q;
        mispred_count_d = (is_mispred && (mispred_count_q != 32'hFFFF_FFFF))
                          ? mispred_count_q + 32'd1 : mispred_count_q;
        underflow_d     = underflow_q || (res_valid && (occ_q == '0));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q          <= '0;
            tail_q          <= '0;
            occ_q           <= '0;
            mispred_q       <= 1'b0;
            redirect_pc_q   <= '0;
            actual_pred_q   <= 1'b0;
            update_opcode_q <= '0;
            update_pc_q     <= '0;
            mispred_count_q <= '0;
            underflow_q     <= 1'b0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            occ_q           <= occ_d;
            mispred_q       <= mispred_d;
            redirect_pc_q   <= redirect_pc_d;
            actual_pred_q   <= actual_pred_d;
            update_opcode_q <= update_opcode_d;
            update_pc_q     <= update_pc_d;
            mispred_count_q <= mispred_count_d;
            underflow_q     <= underflow_d;
        end
    end

    // Entry storage needs no reset: occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            queue_q[tail_q] <= enq_entry;
        end
    end

    assign mispred       = mispred_q;
    assign redirect_pc   = redirect_pc_q;
    assign actual_pred   = actual_pred_q;
    assign update_opcode = update_opcode_q;
    assign update_pc     = update_pc_q;
    assign occupancy     = occ_q;
    assign mispred_count = mispred_count_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed-vector bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic        enq_pred_taken;
    logic [31:0] enq_pred_target;
    logic        enq_ready;
    logic        res_valid;
    logic [2:0]  res_funct3;
    logic [31:0] res_rs1, res_rs2;
    logic [12:0] res_imm;
    logic        mispred;
    logic [31:0] redirect_pc;
    logic        actual_pred;
    logic [6:0]  update_opcode;
    logic [31:0] update_pc;
    logic [3:0]  occupancy;
    logic [31:0] mispred_count;
    logic        underflow_err;

    int vectors = 0;
    int miscompares = 0;

    branch_resolve_unit dut (
        .clk             (clk),
        .reset           (reset),
        .enq_valid       (enq_valid),
        .enq_pc          (enq_pc),
        .enq_pred_taken  (enq_pred_taken),
        .enq_pred_target (enq_pred_target),
        .enq_ready       (enq_ready),
        .res_valid       (res_valid),
        .res_funct3      (res_funct3),
        .res_rs1         (res_rs1),
        .res_rs2         (res_rs2),
        .res_imm         (res_imm),
        .mispred         (mispred),
        .redirect_pc     (redirect_pc),
        .actual_pred     (actual_pred),
        .update_opcode   (update_opcode),
        .update_pc       (update_pc),
        .occupancy       (occupancy),
        .mispred_count   (mispred_count),
        .underflow_err   (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        enq_valid       = v;
        enq_pc          = pc;
        enq_pred_taken  = pt;
        enq_pred_target = tgt;
    endtask

    task automatic set_res(input logic v, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [12:0] imm);
        res_valid  = v;
        res_funct3 = f3;
        res_rs1    = a;
        res_rs2    = b;
        res_imm    = imm;
    endtask

    task automatic enqueue(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        set_enq(1'b1, pc, pt, tgt);
        tick();
        set_enq(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [12:0] imm);
        set_res(1'b1, f3, a, b, imm);
        tick();
        set_res(1'b0, 3'b000, 32'h0, 32'h0, 13'h0);
    endtask

    initial begin
        reset = 1'b0;
        set_enq(1'b0, 32'h0, 1'b0, 32'h0);
        set_res(1'b0, 3'b000, 32'h0, 32'h0, 13'h0);
        tick();
        tick();
        reset = 1'b1;

        check("rst_occ",       32'(occupancy),     32'd0);
        check("rst_enq_ready", 32'(enq_ready),     32'd1);
        check("rst_mispred",   32'(mispred),       32'd0);
        check("rst_redirect",  redirect_pc,        32'h0);
        check("rst_opcode",    32'(update_opcode), 32'h0);
        check("rst_upd_pc",    update_pc,          32'h0);
        check("rst_count",     mispred_count,      32'h0);
        check("rst_underflow", 32'(underflow_err), 32'd0);

        // correctly predicted taken BEQ
        enqueue(32'h100, 1'b1, 32'h120);
        check("t1_occ1", 32'(occupancy), 32'd1);
        resolve(3'b000, 32'd5, 32'd5, 13'h020);
        check("t1_mispred",  32'(mispred),       32'd0);
        check("t1_opcode",   32'(update_opcode), 32'h63);
        check("t1_upd_pc",   update_pc,          32'h100);
        check("t1_actual",   32'(actual_pred),   32'd1);
        check("t1_redirect", redirect_pc,        32'h120);
        check("t1_occ0",     32'(occupancy),     32'd0);
        tick();
        check("t1_opcode_idle", 32'(update_opcode), 32'h0);
        check("t1_upd_pc_hold", update_pc,          32'h100);

        // direction mispredict with flush; concurrent enqueue is dropped
        enqueue(32'h200, 1'b0, 32'h0);
        enqueue(32'h204, 1'b0, 32'h0);
        enqueue(32'h208, 1'b0, 32'h0);
        check("t2_occ3", 32'(occupancy), 32'd3);
        set_enq(1'b1, 32'h20C, 1'b0, 32'h0);
        resolve(3'b100, 32'hFFFF_FFFF, 32'h0, 13'h1FF8);
        set_enq(1'b0, 32'h0, 1'b0, 32'h0);
        check("t2_mispred",  32'(mispred),     32'd1);
        check("t2_redirect", redirect_pc,      32'h1F8);
        check("t2_occ0",     32'(occupancy),   32'd0);
        check("t2_count",    mispred_count,    32'd1);
        check("t2_upd_pc",   update_pc,        32'h200);
        tick();
        check("t2_mispred_pulse", 32'(mispred), 32'd0);

        // target mispredict: BNE taken to 0x330, predicted 0x300
        enqueue(32'h2F0, 1'b1, 32'h300);
        resolve(3'b001, 32'd1, 32'd2, 13'h040);
        check("t3_mispred",  32'(mispred),   32'd1);
        check("t3_redirect", redirect_pc,    32'h330);
        check("t3_count",    mispred_count,  32'd2);

        // correctly predicted not-taken BGEU, falls through
        enqueue(32'h400, 1'b0, 32'h0);
        resolve(3'b111, 32'd1, 32'd2, 13'h010);
        check("t4_mispred",  32'(mispred),     32'd0);
        check("t4_actual",   32'(actual_pred), 32'd0);
        check("t4_redirect", redirect_pc,      32'h404);

        // predicted taken, BGE not taken (-1 >= 0 false)
        enqueue(32'h500, 1'b1, 32'h540);
        resolve(3'b101, 32'hFFFF_FFFF, 32'h0, 13'h040);
        check("t5_mispred",  32'(mispred),   32'd1);
        check("t5_redirect", redirect_pc,    32'h504);
        check("t5_count",    mispred_count,  32'd3);

        // fill the queue
        for (int i = 0; i < 8; i++) begin
            enqueue(32'h600 + 32'(4 * i), 1'b0, 32'h0);
        end
        check("t6_occ8",   32'(occupancy), 32'd8);
        check("t6_ready0", 32'(enq_ready), 32'd0);
        enqueue(32'h700, 1'b0, 32'h0);
        check("t6_occ8_after_9th", 32'(occupancy), 32'd8);
        set_enq(1'b1, 32'h704, 1'b0, 32'h0);
        resolve(3'b010, 32'd0, 32'd0, 13'h0);
        set_enq(1'b0, 32'h0, 1'b0, 32'h0);
        check("t6_occ7",     32'(occupancy), 32'd7);
        check("t6_ready1",   32'(enq_ready), 32'd1);
        check("t6_mispred",  32'(mispred),   32'd0);
        check("t6_upd_pc",   update_pc,      32'h600);
        check("t6_redirect", redirect_pc,    32'h604);

        // reset mid-flight with a resolve presented in the reset cycle
        reset = 1'b0;
        set_res(1'b1, 3'b000, 32'd0, 32'd0, 13'h0);
        tick();
        set_res(1'b0, 3'b000, 32'h0, 32'h0, 13'h0);
        reset = 1'b1;
        check("t7_occ",      32'(occupancy),     32'd0);
        check("t7_opcode",   32'(update_opcode), 32'h0);
        check("t7_upd_pc",   update_pc,          32'h0);
        check("t7_redirect", redirect_pc,        32'h0);
        check("t7_count",    mispred_count,      32'h0);
        enqueue(32'h800, 1'b1, 32'h810);
        enqueue(32'h804, 1'b1, 32'h810);
        enqueue(32'h808, 1'b1, 32'h810);
        check("t7_occ3", 32'(occupancy), 32'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t7_occ_after_rst", 32'(occupancy), 32'd0);

        // empty-queue resolve
        resolve(3'b000, 32'd0, 32'd0, 13'h0);
        check("t8_underflow", 32'(underflow_err), 32'd1);
        check("t8_opcode",    32'(update_opcode), 32'h0);
        check("t8_mispred",   32'(mispred),       32'd0);
        tick();
        check("t8_underflow_sticky", 32'(underflow_err), 32'd1);
        check("t8_occ",              32'(occupancy),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolver side of the 2-bit branch prediction interface. It sits between fetch/predict and execute.
- Buffers every predicted conditional branch (PC, predicted direction, predicted target) in an in-order queue.
- At execute it evaluates the real condition, detects mispredictions and issues a front-end redirect.
- It also drives the predictor's BHT update port (update_opcode, update_pc, actual_pred, mispred).

Parameters:
- ADDRESS_BITS, 32, PC and target width.
- DATA_WIDTH, 32, operand width for condition compare.
- QUEUE_DEPTH, 8, in-flight branch entries; power of two, 2 or more.
- LOG2_QUEUE_DEPTH, $clog2(QUEUE_DEPTH), pointer width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- enq_valid  in  1  predicted branch issued by fetch.
- enq_pc  in  ADDRESS_BITS  branch PC.
- enq_pred_taken  in  1  predictor direction.
- enq_pred_target  in  ADDRESS_BITS  predicted taken target.
- enq_ready  out  1  queue not full.
- res_valid  in  1  execute resolving the oldest branch.
- res_funct3  in  3  branch funct3.
- res_rs1, res_rs2  in  DATA_WIDTH  operands.
- res_imm  in  13  B-type immediate, bit 0 = 0.
- mispred  out  1  one-cycle pulse on misprediction.
- redirect_pc  out  ADDRESS_BITS  correct next PC, valid with mispred.
- actual_pred  out  1  resolved direction (1 = taken).
- update_opcode  out  7  7'b1100011 for one cycle per resolved branch, else 7'b0.
- update_pc  out  ADDRESS_BITS  PC of the resolved branch.
- occupancy  out  LOG2_QUEUE_DEPTH+1  valid entries.
- mispred_count  out  32  saturating misprediction counter.
- underflow_err  out  1  sticky: res_valid seen with empty queue.

Behaviour:
- Reset (reset==0 at posedge):
  - head, tail and occupancy are 0.
  - All registered outputs are 0: mispred, redirect_pc, actual_pred, update_opcode, update_pc, mispred_count, underflow_err.
  - Queue contents are don't-care.
  - enq_ready reads 1 in the first cycle after reset.
  - Reset asserted mid-operation discards all entries, with no update or redirect emitted.
- Queue: circular FIFO.
  - Enqueue when enq_valid && enq_ready.
  - enq_ready = (occupancy != QUEUE_DEPTH), combinational.
  - Pointers wrap modulo QUEUE_DEPTH.
- Resolve: when res_valid and occupancy > 0, pop the head entry. Condition is taken as follows:
  - 000 eq
  - 001 ne
  - 100 signed lt
  - 101 signed ge
  - 110 unsigned lt
  - 111 unsigned ge
  - 010 and 011 give not-taken.
- Target arithmetic:
  - taken_tgt = head.pc + sign-extend(res_imm) to ADDRESS_BITS, modulo 2^ADDRESS_BITS.
  - next_pc = taken ? taken_tgt : head.pc + 4.
- Mispredict:
  - Occurs when (taken != pred_taken) || (taken && pred_taken && taken_tgt != pred_target).
- Output latency: one cycle. Outputs are registered in the cycle after the res_valid cycle:
  - update_opcode = 7'b1100011
  - update_pc = head.pc
  - actual_pred = taken
  - mispred as above
  - redirect_pc = next_pc
- Outputs in other cycles:
  - update_opcode and mispred return to 0.
  - redirect_pc, update_pc and actual_pred hold their last value.
- Flush:
  - On a mispredict, all entries younger than the head are discarded in the same edge that pops the head.
  - After that edge, occupancy is 0 and tail equals head.
  - A simultaneous enqueue in the mispredict cycle is dropped, because it is wrong-path.
- Simultaneous enqueue and non-mispredict resolve: both take effect; occupancy is unchanged. When full, enq_ready = 0 even if a resolve pops in that cycle (no full-bypass).
- Empty-queue resolve: res_valid with occupancy == 0 sets underflow_err (sticky until reset) and produces no update or mispred.
- mispred_count increments on each mispredict and saturates at 32'hFFFF_FFFF.

Decomposition:
- Package bp_pkg holds:
  - OPC_BRANCH = 7'b1100011
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - the queue entry struct {pc, pred_taken, pred_target}.
  - The package is shared with branch_predictor_2_bit.
- One sub-module, branch_compare: purely combinational funct3/operand evaluation producing taken.

Test Plan:
- Correctly predicted taken branch:
  - Stimulus: enqueue pc=0x100, pred_taken=1, target=0x120; resolve BEQ with rs1=rs2=5, imm=0x20.
  - Response: next cycle mispred=0, update_opcode=0x63, update_pc=0x100, actual_pred=1; occupancy 1→0.
- Direction mispredict with flush:
  - Stimulus: enqueue 0x200 (pred 0), 0x204 and 0x208; resolve BLT with rs1=-1, rs2=0, imm=-8.
  - Response: mispred=1, redirect_pc=0x1F8, occupancy=0, mispred_count=1.
- Target mispredict:
  - Stimulus: pred_taken=1, target=0x300; actual BNE taken with pc=0x2F0, imm=0x40.
  - Response: mispred=1, redirect_pc=0x330.
- Full queue:
  - Stimulus: 8 enqueues with no resolves.
  - Response: enq_ready=0. A 9th enq_valid is ignored. One resolve plus enqueue in the same cycle while full leaves occupancy at 7, then enq_ready=1.
- Empty resolve:
  - Stimulus: res_valid with an empty queue.
  - Response: underflow_err=1 and stays 1; update_opcode stays 0.
- Reset mid-flight:
  - Stimulus: 3 entries queued, then reset=0 for one cycle.
  - Response: occupancy=0, all outputs 0, and a subsequent resolve raises underflow_err.
